// File: rtl/dsm_pkg.sv
// Shared widths, feedback magnitude and the saturating three-term adder used by
// both integrator stages of the second-order delta-sigma modulator.
package dsm_pkg;

    localparam int IN_W  = 20;
    localparam int ACC_W = 26;
    localparam int SUM_W = ACC_W + 2;

    localparam logic signed [ACC_W-1:0] FB_MAG  = ACC_W'(2 ** (IN_W - 1));
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

    // a + b - c evaluated two bits wider than the accumulator, then clamped so
    // the integrators can pin at a rail but never wrap to the opposite sign.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b,
        input logic signed [ACC_W-1:0] c
    );
        logic signed [SUM_W-1:0] w_a;
        logic signed [SUM_W-1:0] w_b;
        logic signed [SUM_W-1:0] w_c;
        logic signed [SUM_W-1:0] w_sum;
        w_a   = $signed({{2{a[ACC_W-1]}}, a});
        w_b   = $signed({{2{b[ACC_W-1]}}, b});
        w_c   = $signed({{2{c[ACC_W-1]}}, c});
        w_sum = w_a + w_b - w_c;
        if (w_sum > ACC_MAX) begin
            return ACC_MAX[ACC_W-1:0];
        end else if (w_sum < ACC_MIN) begin
            return ACC_MIN[ACC_W-1:0];
        end else begin
            return w_sum[ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/dsm_integrator.sv
// One saturating integrator stage: acc <= sat(acc + in - fb), with the
// combinational next value exported so a following stage can use it this cycle.
module dsm_integrator
    import dsm_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [ACC_W-1:0] in,
    input  logic signed [ACC_W-1:0] fb,
    output logic signed [ACC_W-1:0] sum_n,
    output logic signed [ACC_W-1:0] acc
);

    always_comb begin
        sum_n = sat_add(acc, in, fb);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= sum_n;
        end
    end

endmodule

// File: rtl/dsm_top.sv
// Second-order 1-bit delta-sigma modulator: registered input, two cascaded
// saturating integrators sharing one feedback value, and a registered quantizer.
module dsm_top
    import dsm_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] vin,
    output logic            pwm
);

    logic signed [ACC_W-1:0] r_x;
    logic                    r_pwm;
    logic signed [ACC_W-1:0] w_x_n;
    logic signed [ACC_W-1:0] w_fb;
    logic signed [ACC_W-1:0] w_sum1;
    logic signed [ACC_W-1:0] w_sum2;
    logic signed [ACC_W-1:0] w_i1_unused;
    logic signed [ACC_W-1:0] w_i2_unused;

    // Offset binary to two's complement is an MSB flip; the flipped MSB is also the sign.
    assign w_x_n = {{(ACC_W - IN_W + 1){~vin[IN_W-1]}}, vin[IN_W-2:0]};

    assign w_fb = r_pwm ? FB_MAG : -FB_MAG;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x   <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_x   <= w_x_n;
            r_pwm <= ~w_sum2[ACC_W-1];
        end
    end

    assign pwm = r_pwm;

    // Stage 2 consumes stage 1's next value, not its register, to avoid an extra loop delay.
    dsm_integrator u_int1 (
        .clock (clock),
        .reset (reset),
        .in    (r_x),
        .fb    (w_fb),
        .sum_n (w_sum1),
        .acc   (w_i1_unused)
    );

    dsm_integrator u_int2 (
        .clock (clock),
        .reset (reset),
        .in    (w_sum1),
        .fb    (w_fb),
        .sum_n (w_sum2),
        .acc   (w_i2_unused)
    );

endmodule

// File: tb/tb_dsm_top.sv
// Scoreboard bench for dsm_top: a behavioural loop model predicts every pwm bit,
// plus density, balance, saturation and sine-reconstruction checks.
`timescale 1ns/1ps
module tb_dsm_top;

    localparam longint FBM  = 64'sd524288;
    localparam longint AMAX = (64'sd1 <<< 25) - 1;
    localparam longint AMIN = -(64'sd1 <<< 25);

    typedef struct packed {
        logic        exp_pwm;
        logic        dens;
        logic        ana;
        logic        bal;
        logic [19:0] vin_lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] vin   = 20'h80000;
    logic        pwm;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];

    longint m_x  = 0;
    longint m_i1 = 0;
    longint m_i2 = 0;
    bit     m_p  = 1'b0;
    logic [19:0] prev_v = 20'h80000;

    int dens_n    = 0;
    int dens_ones = 0;
    int bal_n     = 0;
    logic [3:0] bal_hist = 4'h0;

    bit  wp[$];
    real wv[$];
    int  sp = 0;
    real sv = 0.0;
    int  an_n = 0;
    real an_e = 0.0;
    real an_s = 0.0;
    real an_ss = 0.0;

    always #5 clock = ~clock;

    dsm_top dut (
        .clock (clock),
        .reset (reset),
        .vin   (vin),
        .pwm   (pwm)
    );

    function automatic void chk(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void chk_bp(input string name, input int ones, input int n,
                                   input int lo_bp, input int hi_bp);
        longint s;
        s = longint'(ones) * 10000;
        total++;
        if (n == 0 || s < longint'(lo_bp) * n || s > longint'(hi_bp) * n) begin
            bad++;
            $display("FAIL %s: ones=%0d of %0d, required between %0d and %0d basis points",
                     name, ones, n, lo_bp, hi_bp);
        end
    endfunction

    function automatic void chk_small(input string name, input real act, input real tol);
        total++;
        if (act > tol || act < -tol) begin
            bad++;
            $display("FAIL %s: actual=%f required magnitude <= %f", name, act, tol);
        end
    endfunction

    function automatic longint sat(input longint s);
        if (s > AMAX) return AMAX;
        if (s < AMIN) return AMIN;
        return s;
    endfunction

    // Loop equations: both integrators see the bit currently on the output as
    // feedback, the second integrates the first one's fresh value, and the input
    // reaches the loop one clock after it is sampled.
    function automatic void model_step(input bit r, input logic [19:0] v);
        longint fb;
        longint n1;
        longint n2;
        if (r) begin
            m_x = 0; m_i1 = 0; m_i2 = 0; m_p = 1'b0;
        end else begin
            fb   = m_p ? FBM : -FBM;
            n1   = sat(m_i1 + m_x - fb);
            n2   = sat(m_i2 + n1 - fb);
            m_i1 = n1;
            m_i2 = n2;
            m_p  = (n2 >= 0);
            m_x  = longint'(v) - FBM;
        end
    endfunction

    task automatic drive(input bit r, input logic [19:0] v, input bit dens, input bit ana,
                         input bit bal);
        exp_t e;
        @(negedge clock);
        #1;
        reset = r;
        vin   = v;
        model_step(r, v);
        e.exp_pwm = m_p;
        e.dens    = dens;
        e.ana     = ana;
        e.bal     = bal;
        e.vin_lat = prev_v;
        prev_v    = v;
        exp_q.push_back(e);
    endtask

    task automatic check_state(input string tag);
        @(posedge clock);
        #1;
        chk({tag, "_pwm"}, pwm, m_p);
        chk({tag, "_i1"}, dut.u_int1.acc, m_i1);
        chk({tag, "_i2"}, dut.u_int2.acc, m_i2);
    endtask

    task automatic run_const(input logic [19:0] v, input int settle, input int n,
                             input bit bal_tail);
        for (int i = 0; i < settle; i++) drive(1'b0, v, 1'b0, 1'b0, 1'b0);
        dens_n    = 0;
        dens_ones = 0;
        for (int i = 0; i < n; i++) drive(1'b0, v, 1'b1, 1'b0, bal_tail && (i >= n - 256));
        drive(1'b0, v, 1'b0, 1'b0, 1'b0);
        drive(1'b0, v, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        real  mr;
        real  rr;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pwm_bit", pwm, e.exp_pwm);
                if (e.dens) begin
                    dens_n++;
                    dens_ones += int'(pwm);
                end
                if (e.bal) begin
                    bal_hist = {bal_hist[2:0], pwm};
                    bal_n++;
                    if (bal_n >= 4) chk("balance_4win", $countones(bal_hist), 2);
                end
                if (e.ana) begin
                    wp.push_back(pwm);
                    wv.push_back(real'(e.vin_lat) / 1048576.0);
                    sp += int'(pwm);
                    sv += real'(e.vin_lat) / 1048576.0;
                    if (wp.size() > 64) begin
                        sp -= int'(wp.pop_front());
                        sv -= wv.pop_front();
                    end
                    if (wp.size() == 64) begin
                        mr = real'(sp) / 64.0;
                        rr = sv / 64.0;
                        an_n++;
                        an_e  += mr - rr;
                        an_s  += (mr - rr) * (rr - 0.5);
                        an_ss += (rr - 0.5) * (rr - 0.5);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [19:0] v;
        int          len;
        int          mode;
        real         ph;

        for (int i = 0; i < 3; i++) drive(1'b1, 20'h80000, 1'b0, 1'b0, 1'b0);
        check_state("rst_hold");

        bal_n = 0;
        run_const(20'h80000, 0, 2048, 1'b1);
        chk_bp("dens_mid", dens_ones, dens_n, 4980, 5020);

        run_const(20'hC0000, 64, 4096, 1'b0);
        chk_bp("dens_75", dens_ones, dens_n, 7480, 7520);

        run_const(20'h33333, 64, 4096, 1'b0);
        chk_bp("dens_20", dens_ones, dens_n, 1980, 2020);

        run_const(20'h00000, 64, 2048, 1'b0);
        chk_bp("dens_neg_fs", dens_ones, dens_n, 0, 9);
        check_state("neg_fs_sat");

        run_const(20'hFFFFF, 64, 2048, 1'b0);
        chk_bp("dens_pos_fs", dens_ones, dens_n, 9991, 10000);
        check_state("pos_fs_sat");

        run_const(20'h80000, 64, 2048, 1'b0);
        chk_bp("dens_step_back", dens_ones, dens_n, 4980, 5020);
        check_state("step_back");

        // Reset while the output is pinned high must clear it on the very next edge.
        for (int i = 0; i < 40; i++) drive(1'b0, 20'hFFFFF, 1'b0, 1'b0, 1'b0);
        chk("pinned_high", m_p, 1);
        drive(1'b1, 20'hFFFFF, 1'b0, 1'b0, 1'b0);
        check_state("mid_rst");

        for (int i = 0; i < 4200; i++) begin
            ph = 2.0 * 3.14159265358979 * real'(i) / 1000.0;
            v  = 20'(524288 + int'(196608.0 * $sin(ph)));
            drive(1'b0, v, 1'b0, (i >= 200), 1'b0);
        end
        drive(1'b0, v, 1'b0, 1'b0, 1'b0);
        drive(1'b0, v, 1'b0, 1'b0, 1'b0);
        chk("sine_windows", an_n, 4000 - 63);
        if (an_n > 0 && an_ss > 0.0) begin
            chk_small("sine_dc_err", an_e / real'(an_n), 0.005);
            chk_small("sine_amp_err", (an_s / an_ss) * 0.1875, 0.005);
        end

        for (int seg = 0; seg < 10; seg++) begin
            if (seg == 2 || $urandom_range(0, 3) == 0) begin
                drive(1'b1, 20'($urandom), 1'b0, 1'b0, 1'b0);
                check_state("rand_rst");
            end
            len  = $urandom_range(40, 200);
            mode = $urandom_range(0, 2);
            v    = 20'($urandom);
            for (int i = 0; i < len; i++) begin
                if (mode == 1) v = 20'($urandom);
                if (mode == 2) v = ($urandom_range(0, 1) == 1) ? 20'hFFFFF : 20'h00000;
                drive(1'b0, v, 1'b0, 1'b0, 1'b0);
            end
            check_state("rand_seg");
        end

        drive(1'b0, 20'h80000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 20'h80000, 1'b0, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
